dm_sb_master: RTL and testbench
===============================

DM_SB_MASTER -- requirements
Module: dm_sb_master

Interface
REQ-001 Parameter: BusWidth, default 32, system-bus data/address width; only 32 or 64 legal, elaboration fatal otherwise.
REQ-002 One clock; reset is synchronous and active-high: clk_i  input  1  rising-edge clock.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 dmactive_i  input  1  debug module active; low forces idle.
REQ-005 sbaddress_i  input  BusWidth  address written by CSR block.
REQ-006 sbaddress_write_valid_i  input  1  one-cycle strobe: sbaddress_i written.
REQ-007 sbreadonaddr_i / sbreadondata_i / sbautoincrement_i  input  1 each  SBCS control bits.
REQ-008 sbaccess_i  input  3  access size code, bytes = 2^sbaccess_i.
REQ-009 sbdata_i  input  BusWidth  write data; sbdata_write_valid_i / sbdata_read_valid_i  input  1 each  one-cycle strobes: sbdata0 written / read.
REQ-010 sbaddress_o  output  BusWidth  current (incremented) address.
REQ-011 sbdata_o  output  BusWidth  lane-aligned read data; sbdata_valid_o  output  1  read data valid pulse.
REQ-012 sbbusy_o  output  1; sberror_valid_o  output  1; sberror_o  output  3.
REQ-013 master_req_o, master_we_o  output  1; master_add_o, master_wdata_o  output  BusWidth; master_be_o  output  BusWidth/8.
REQ-014 master_gnt_i, master_r_valid_i  input  1; master_r_rdata_i  input  BusWidth.

Function
REQ-015 FSM states IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE; sbbusy_o = (state != IDLE).
REQ-016 Address register loads sbaddress_i on sbaddress_write_valid_i in IDLE; ignored outside IDLE.
REQ-017 IDLE priority: (addr strobe & sbreadonaddr_i) -> READ; else sbdata_write_valid_i -> WRITE; else (sbdata_read_valid_i & sbreadondata_i) -> READ; else stay.
REQ-018 Read-on-address uses the newly loaded address.
REQ-019 Write data latched from sbdata_i on the WRITE transition.
REQ-020 READ/WRITE: master_req_o=1, master_add_o=address, master_we_o=1 only in WRITE; held stable until master_gnt_i; gnt -> WAIT_READ/WAIT_WRITE next cycle.
REQ-021 WAIT_READ: on master_r_valid_i, sbdata_valid_o=1 same cycle, return IDLE; WAIT_WRITE: on master_r_valid_i return IDLE.
REQ-022 On completion with sbautoincrement_i=1, address += 2^sbaccess_i (modulo 2^BusWidth, wraps).
REQ-023 Size check in READ/WRITE before req: 2^sbaccess_i > BusWidth/8 -> no request, sberror_o=4, sberror_valid_o=1 for one cycle, return IDLE.
REQ-024 Alignment check: address not multiple of 2^sbaccess_i -> no request, sberror_o=3, one-cycle pulse, IDLE; size error wins.
REQ-025 sberror_o is 0 whenever sberror_valid_o=0.
REQ-026 master_be_o = ((1<<2^sbaccess_i)-1) << byte offset, offset = address mod (BusWidth/8).
REQ-027 master_wdata_o = latched data << (8*offset); sbdata_o = (master_r_rdata_i >> 8*offset) with bits above 8*2^sbaccess_i zeroed.
REQ-028 Strobes arriving while busy are ignored (CSR block reports busy error).
REQ-029 dmactive_i=0: next cycle state IDLE, master_req_o=0, no pulses; address retained.

Reset
REQ-030 rst_i: state IDLE, address 0, latched write data 0; all outputs 0 the cycle after reset asserts.
REQ-031 Reset mid-transaction abandons it; no sbdata_valid_o or error pulse produced.

Structure
REQ-032 Shared package dm_pkg: state enum, sberror codes (0 none, 3 alignment, 4 size), sbaccess size constants.
REQ-033 Single module; optional sub-module dm_sb_lane (byte-enable/data lane alignment).

Verification
REQ-034 addr 0x100 with readonaddr, sbaccess=2, gnt immediate, r_valid next, rdata 0xDEADBEEF -> sbdata_o 0xDEADBEEF, valid pulse, busy 3 cycles.
REQ-035 Write 0x11223344 at 0x202 sbaccess=1 -> be 0b1100, wdata 0x33440000, we=1.
REQ-036 Autoincrement, sbaccess=2, two readondata reads from 0x1000 -> second request at 0x1004, sbaddress_o 0x1008.
REQ-037 BusWidth=32, sbaccess=3 write -> no req, sberror 4 pulse; addr 0x101 sbaccess=2 -> sberror 3.
REQ-038 gnt delayed 5 cycles -> req/addr stable throughout; dmactive_i dropped in WAIT_READ -> IDLE, no valid pulse.

Source files
------------

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the system-bus access master
package dm_pkg;

  typedef enum logic [2:0] {
    SB_IDLE       = 3'd0,
    SB_READ       = 3'd1,
    SB_WRITE      = 3'd2,
    SB_WAIT_READ  = 3'd3,
    SB_WAIT_WRITE = 3'd4
  } sb_state_e;

  localparam logic [2:0] SBERR_NONE  = 3'd0;
  localparam logic [2:0] SBERR_ALIGN = 3'd3;
  localparam logic [2:0] SBERR_SIZE  = 3'd4;

  localparam logic [2:0] SBACCESS_8   = 3'd0;
  localparam logic [2:0] SBACCESS_16  = 3'd1;
  localparam logic [2:0] SBACCESS_32  = 3'd2;
  localparam logic [2:0] SBACCESS_64  = 3'd3;
  localparam logic [2:0] SBACCESS_128 = 3'd4;

  // Largest legal sbaccess code for a bus of the given width (log2 of bytes per beat).
  function automatic int max_sbaccess(input int bus_width);
    return $clog2(bus_width / 8);
  endfunction

endpackage

// File: rtl/dm_sb_master_if.sv
// rtl/dm_sb_master_if.sv - request/grant/response system-bus port between master and slave
interface dm_sb_master_if #(
  parameter int BusWidth = 32
);

  logic                    req;
  logic                    we;
  logic [BusWidth-1:0]     add;
  logic [BusWidth-1:0]     wdata;
  logic [BusWidth/8-1:0]   be;
  logic                    gnt;
  logic                    r_valid;
  logic [BusWidth-1:0]     r_rdata;

  modport master (
    output req, we, add, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, we, add, wdata, be,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/dm_sb_lane.sv
// rtl/dm_sb_lane.sv - byte-enable generation and data lane alignment for sub-word accesses
module dm_sb_lane
  import dm_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic [$clog2(BusWidth/8)-1:0] offset_i,
  input  logic [2:0]                    sbaccess_i,
  input  logic [BusWidth-1:0]           wdata_i,
  input  logic [BusWidth-1:0]           rdata_i,
  output logic [BusWidth/8-1:0]         be_o,
  output logic [BusWidth-1:0]           wdata_o,
  output logic [BusWidth-1:0]           rdata_o
);

  localparam int NBytes = BusWidth / 8;

  logic [BusWidth-1:0] rshift;

  always_comb begin
    int nbytes;
    int off;
    nbytes  = 1 << int'(sbaccess_i);
    off     = int'(offset_i);
    rshift  = rdata_i >> {offset_i, 3'b000};
    wdata_o = wdata_i << {offset_i, 3'b000};
    be_o    = '0;
    rdata_o = '0;
    // Byte lanes outside the access window are masked on both directions.
    for (int i = 0; i < NBytes; i++) begin
      be_o[i] = (i >= off) && (i < off + nbytes);
      if (i < nbytes) begin
        rdata_o[8*i +: 8] = rshift[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dm_sb_master.sv
// rtl/dm_sb_master.sv - debug-module system-bus master: SBCS-driven single reads/writes
module dm_sb_master
  import dm_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dmactive_i,
  input  logic [BusWidth-1:0] sbaddress_i,
  input  logic                sbaddress_write_valid_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbreadondata_i,
  input  logic                sbautoincrement_i,
  input  logic [2:0]          sbaccess_i,
  input  logic [BusWidth-1:0] sbdata_i,
  input  logic                sbdata_write_valid_i,
  input  logic                sbdata_read_valid_i,
  output logic [BusWidth-1:0] sbaddress_o,
  output logic [BusWidth-1:0] sbdata_o,
  output logic                sbdata_valid_o,
  output logic                sbbusy_o,
  output logic                sberror_valid_o,
  output logic [2:0]          sberror_o,
  dm_sb_master_if.master      bus
);

  localparam int OffW      = $clog2(BusWidth / 8);
  localparam int MaxAccess = max_sbaccess(BusWidth);

  if (!(BusWidth == 32 || BusWidth == 64)) begin : g_bad_width
    $fatal(1, "dm_sb_master: BusWidth must be 32 or 64");
  end

  sb_state_e           state_q;
  logic [BusWidth-1:0] addr_q;
  logic [BusWidth-1:0] wdata_q;
  logic                req_q;
  logic                err_valid_q;
  logic [2:0]          err_q;

  logic [BusWidth-1:0]   access_bytes;
  logic                  size_err;
  logic                  align_err;
  logic [BusWidth/8-1:0] lane_be;
  logic [BusWidth-1:0]   lane_wdata;
  logic [BusWidth-1:0]   lane_rdata;

  assign access_bytes = BusWidth'(1) << sbaccess_i;
  assign size_err     = sbaccess_i > 3'(MaxAccess);
  assign align_err    = |(addr_q & (access_bytes - BusWidth'(1)));

  dm_sb_lane #(.BusWidth(BusWidth)) u_lane (
    .offset_i   (addr_q[OffW-1:0]),
    .sbaccess_i (sbaccess_i),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.r_rdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  // The first cycle in READ/WRITE only runs the size/alignment checks; req rises after.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SB_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_q       <= 1'b0;
      err_valid_q <= 1'b0;
      err_q       <= SBERR_NONE;
    end else begin
      err_valid_q <= 1'b0;
      err_q       <= SBERR_NONE;
      if (!dmactive_i) begin
        state_q <= SB_IDLE;
        req_q   <= 1'b0;
      end else begin
        unique case (state_q)
          SB_IDLE: begin
            if (sbaddress_write_valid_i) begin
              addr_q <= sbaddress_i;
            end
            if (sbaddress_write_valid_i && sbreadonaddr_i) begin
              state_q <= SB_READ;
            end else if (sbdata_write_valid_i) begin
              state_q <= SB_WRITE;
              wdata_q <= sbdata_i;
            end else if (sbdata_read_valid_i && sbreadondata_i) begin
              state_q <= SB_READ;
            end
          end
          SB_READ, SB_WRITE: begin
            if (!req_q) begin
              if (size_err) begin
                err_valid_q <= 1'b1;
                err_q       <= SBERR_SIZE;
                state_q     <= SB_IDLE;
              end else if (align_err) begin
                err_valid_q <= 1'b1;
                err_q       <= SBERR_ALIGN;
                state_q     <= SB_IDLE;
              end else begin
                req_q <= 1'b1;
              end
            end else if (bus.gnt) begin
              req_q   <= 1'b0;
              state_q <= (state_q == SB_READ) ? SB_WAIT_READ : SB_WAIT_WRITE;
            end
          end
          SB_WAIT_READ, SB_WAIT_WRITE: begin
            if (bus.r_valid) begin
              state_q <= SB_IDLE;
              if (sbautoincrement_i) begin
                addr_q <= addr_q + access_bytes;
              end
            end
          end
          default: state_q <= SB_IDLE;
        endcase
      end
    end
  end

  assign bus.req     = req_q;
  assign bus.we      = req_q && (state_q == SB_WRITE);
  assign bus.add     = addr_q;
  assign bus.be      = req_q ? lane_be : '0;
  assign bus.wdata   = (req_q && (state_q == SB_WRITE)) ? lane_wdata : '0;

  assign sbaddress_o     = addr_q;
  assign sbbusy_o        = (state_q != SB_IDLE);
  assign sbdata_valid_o  = !rst_i && dmactive_i && (state_q == SB_WAIT_READ) && bus.r_valid;
  assign sbdata_o        = sbdata_valid_o ? lane_rdata : '0;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;

endmodule

// File: tb/tb_dm_sb_master.sv
// tb/tb_dm_sb_master.sv - self-checking bench for dm_sb_master with a responding bus slave
module tb_dm_sb_master;
  import dm_pkg::*;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          dmactive_i;
  logic [BW-1:0] sbaddress_i;
  logic          sbaddress_write_valid_i;
  logic          sbreadonaddr_i;
  logic          sbreadondata_i;
  logic          sbautoincrement_i;
  logic [2:0]    sbaccess_i;
  logic [BW-1:0] sbdata_i;
  logic          sbdata_write_valid_i;
  logic          sbdata_read_valid_i;
  logic [BW-1:0] sbaddress_o;
  logic [BW-1:0] sbdata_o;
  logic          sbdata_valid_o;
  logic          sbbusy_o;
  logic          sberror_valid_o;
  logic [2:0]    sberror_o;

  always #5 clk = ~clk;

  dm_sb_master_if #(.BusWidth(BW)) bus_if ();

  dm_sb_master #(.BusWidth(BW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .dmactive_i              (dmactive_i),
    .sbaddress_i             (sbaddress_i),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbaccess_i              (sbaccess_i),
    .sbdata_i                (sbdata_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbaddress_o             (sbaddress_o),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sberror_valid_o         (sberror_valid_o),
    .sberror_o               (sberror_o),
    .bus                     (bus_if)
  );

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [2:0]  acc;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    logic [2:0]  err;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd_q [$];
  logic [2:0]  exp_err_q [$];

  int          busy_cnt, req_count, req_cycles, gnt_delay, wait_cnt;
  bit          no_resp, pend_r, unstable;
  logic [31:0] rd_word, pend_data, first_add, last_add, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: slave reacts just after the edge, scoreboard samples after settling.
  task automatic cycle();
    @(posedge clk);
    #1;
    bus_if.r_valid = 1'b0;
    bus_if.r_rdata = '0;
    if (pend_r) begin
      bus_if.r_valid = 1'b1;
      bus_if.r_rdata = pend_data;
      pend_r = 1'b0;
    end
    bus_if.gnt = 1'b0;
    if (bus_if.req) begin
      if (req_cycles == 0) first_add = bus_if.add;
      else if (bus_if.add !== first_add) unstable = 1'b1;
      req_cycles++;
      if (wait_cnt >= gnt_delay) begin
        bus_if.gnt = 1'b1;
        wait_cnt   = 0;
        req_count++;
        last_add   = bus_if.add;
        last_be    = bus_if.be;
        last_we    = bus_if.we;
        last_wdata = bus_if.wdata;
        if (!no_resp) begin
          pend_r    = 1'b1;
          pend_data = rd_word;
        end
      end else begin
        wait_cnt++;
      end
    end
    #1;
    if (sbbusy_o) busy_cnt++;
    if (sbdata_valid_o) begin
      if (exp_rd_q.size() == 0) check("rdata_valid_unexpected", sbdata_valid_o, 0);
      else check("sbdata", sbdata_o, exp_rd_q.pop_front());
    end
    if (sberror_valid_o) begin
      if (exp_err_q.size() == 0) check("err_valid_unexpected", sberror_valid_o, 0);
      else check("sberror", sberror_o, exp_err_q.pop_front());
    end else begin
      check("sberror_idle_zero", sberror_o, 0);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbbusy_o && n < 50) begin
      cycle();
      n++;
    end
    if (n >= 50) check("timeout_busy", sbbusy_o, 0);
  endtask

  task automatic run_txn(input logic is_read, input logic [31:0] addr, input logic [2:0] acc,
                         input logic [31:0] wd);
    sbaccess_i              = acc;
    sbaddress_i             = addr;
    sbaddress_write_valid_i = 1'b1;
    sbreadonaddr_i          = is_read;
    cycle();
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i          = 1'b0;
    if (!is_read) begin
      sbdata_i             = wd;
      sbdata_write_valid_i = 1'b1;
      cycle();
      sbdata_write_valid_i = 1'b0;
    end
    wait_idle();
  endtask

  // Start a read that the slave grants but never answers; returns in WAIT_READ.
  task automatic start_stuck_read(input logic [31:0] addr);
    no_resp                 = 1'b1;
    sbaccess_i              = SBACCESS_32;
    sbaddress_i             = addr;
    sbaddress_write_valid_i = 1'b1;
    sbreadonaddr_i          = 1'b1;
    cycle();
    sbaddress_write_valid_i = 1'b0;
    sbreadonaddr_i          = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    int rc;
    vecs[0] = '{1'b1, 32'h0000_0100, SBACCESS_32, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, SBERR_NONE};
    vecs[1] = '{1'b0, 32'h0000_0202, SBACCESS_16, 32'h1122_3344, 4'b1100, 32'h3344_0000, SBERR_NONE};
    vecs[2] = '{1'b1, 32'h0000_0203, SBACCESS_8,  32'hAABB_CCDD, 4'b1000, 32'h0000_00AA, SBERR_NONE};
    vecs[3] = '{1'b1, 32'h0000_0202, SBACCESS_16, 32'hAABB_CCDD, 4'b1100, 32'h0000_AABB, SBERR_NONE};
    vecs[4] = '{1'b0, 32'h0000_0301, SBACCESS_8,  32'h0000_00EE, 4'b0010, 32'h0000_EE00, SBERR_NONE};
    vecs[5] = '{1'b0, 32'h0000_0400, SBACCESS_64, 32'h0102_0304, 4'b0000, 32'h0,         SBERR_SIZE};
    vecs[6] = '{1'b1, 32'h0000_0101, SBACCESS_32, 32'h0,         4'b0000, 32'h0,         SBERR_ALIGN};
    vecs[7] = '{1'b1, 32'h0000_0103, SBACCESS_16, 32'h0,         4'b0000, 32'h0,         SBERR_ALIGN};
    vecs[8] = '{1'b0, 32'h0000_0105, 3'd5,        32'h0,         4'b0000, 32'h0,         SBERR_SIZE};
    vecs[9] = '{1'b0, 32'h0000_0108, SBACCESS_32, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, SBERR_NONE};

    rst_i = 1'b1; dmactive_i = 1'b1;
    sbaddress_i = '0; sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    sbreadondata_i = 1'b0; sbautoincrement_i = 1'b0; sbaccess_i = SBACCESS_32;
    sbdata_i = '0; sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;
    bus_if.gnt = 1'b0; bus_if.r_valid = 1'b0; bus_if.r_rdata = '0;
    busy_cnt = 0; req_count = 0; req_cycles = 0; gnt_delay = 0; wait_cnt = 0;
    no_resp = 1'b0; pend_r = 1'b0; unstable = 1'b0; rd_word = '0; pend_data = '0;
    first_add = '0; last_add = '0; last_wdata = '0; last_be = '0; last_we = 1'b0;

    cycle();
    cycle();
    check("rst_busy", sbbusy_o, 0);
    check("rst_addr", sbaddress_o, 0);
    check("rst_req", bus_if.req, 0);
    check("rst_we", bus_if.we, 0);
    check("rst_be", bus_if.be, 0);
    check("rst_wdata", bus_if.wdata, 0);
    check("rst_add", bus_if.add, 0);
    check("rst_sbdata", {sbdata_valid_o, sbdata_o}, 0);
    check("rst_err", {sberror_valid_o, sberror_o}, 0);
    rst_i = 1'b0;
    cycle();

    for (int i = 0; i < NV; i++) begin
      rd_word = vecs[i].data;
      if (vecs[i].err != SBERR_NONE) exp_err_q.push_back(vecs[i].err);
      else if (vecs[i].rd) exp_rd_q.push_back(vecs[i].exp);
      rc = req_count;
      busy_cnt = 0;
      req_cycles = 0;
      run_txn(vecs[i].rd, vecs[i].addr, vecs[i].acc, vecs[i].data);
      if (vecs[i].err != SBERR_NONE) begin
        check($sformatf("v%0d_noreq", i), req_count - rc, 0);
      end else begin
        check($sformatf("v%0d_req", i), req_count - rc, 1);
        check($sformatf("v%0d_add", i), last_add, vecs[i].addr);
        check($sformatf("v%0d_be", i), last_be, vecs[i].be);
        check($sformatf("v%0d_we", i), last_we, !vecs[i].rd);
        if (!vecs[i].rd) check($sformatf("v%0d_wdata", i), last_wdata, vecs[i].exp);
      end
      if (i == 0) check("v0_busy_cycles", busy_cnt, 3);
      cycle();
    end
    check("sb_rd_drained", exp_rd_q.size(), 0);
    check("sb_err_drained", exp_err_q.size(), 0);

    // Read-on-data with autoincrement, then address wrap at the top of the space.
    sbautoincrement_i = 1'b1;
    sbreadondata_i    = 1'b1;
    sbaccess_i        = SBACCESS_32;
    sbaddress_i       = 32'h0000_1000;
    sbaddress_write_valid_i = 1'b1;
    cycle();
    sbaddress_write_valid_i = 1'b0;
    check("ainc_no_read_on_addr", sbbusy_o, 0);
    for (int k = 0; k < 2; k++) begin
      rd_word = 32'h5000_0000 + k;
      exp_rd_q.push_back(rd_word);
      sbdata_read_valid_i = 1'b1;
      cycle();
      sbdata_read_valid_i = 1'b0;
      wait_idle();
      check($sformatf("ainc%0d_add", k), last_add, 32'h1000 + 4 * k);
      check($sformatf("ainc%0d_sbaddr", k), sbaddress_o, 32'h1004 + 4 * k);
    end
    rd_word = 32'h0BAD_F00D;
    exp_rd_q.push_back(rd_word);
    run_txn(1'b1, 32'hFFFF_FFFC, SBACCESS_32, 32'h0);
    check("ainc_wrap", sbaddress_o, 0);
    sbautoincrement_i = 1'b0;
    sbreadondata_i    = 1'b0;

    // Delayed grant; an address strobe while busy must be ignored.
    gnt_delay = 5; req_cycles = 0; unstable = 1'b0;
    rd_word = 32'h1234_5678;
    exp_rd_q.push_back(rd_word);
    sbaccess_i = SBACCESS_32;
    sbaddress_i = 32'h0000_2000; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    cycle();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    cycle();
    cycle();
    sbaddress_i = 32'h0000_3000; sbaddress_write_valid_i = 1'b1; sbreadonaddr_i = 1'b1;
    cycle();
    sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
    wait_idle();
    check("gdly_req_cycles", req_cycles, 6);
    check("gdly_stable", unstable, 0);
    check("gdly_add", last_add, 32'h2000);
    check("gdly_busy_strobe_ignored", sbaddress_o, 32'h2000);
    gnt_delay = 0;
    cycle();

    // dmactive dropped while waiting for the read response.
    start_stuck_read(32'h0000_2400);
    check("dma_in_wait_busy", sbbusy_o, 1);
    check("dma_in_wait_req", bus_if.req, 0);
    dmactive_i = 1'b0;
    cycle();
    check("dma_idle", sbbusy_o, 0);
    check("dma_addr_kept", sbaddress_o, 32'h2400);
    no_resp = 1'b0;
    dmactive_i = 1'b1;
    cycle();
    cycle();
    check("dma_stays_idle", sbbusy_o, 0);

    // Reset in the middle of a transaction.
    start_stuck_read(32'h0000_2800);
    check("rstmid_busy", sbbusy_o, 1);
    rst_i = 1'b1;
    cycle();
    check("rstmid_idle", sbbusy_o, 0);
    check("rstmid_addr", sbaddress_o, 0);
    check("rstmid_req", bus_if.req, 0);
    rst_i = 1'b0;
    no_resp = 1'b0;
    cycle();
    cycle();

    check("final_rd_drained", exp_rd_q.size(), 0);
    check("final_err_drained", exp_err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
